// File: rtl/alu_result_fifo.sv
// First-word-fall-through result FIFO behind the 4-bit ALU, drained over valid/ready.
// Optional flag checker: define ALU_RESFIFO_FLAGCHK_EN to enable the one-hot gt/lt/eq check.
module alu_result_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_s1,
  input  logic          in_s0,
  input  logic [3:0]    in_sum,
  input  logic          in_carry,
  input  logic          in_gt,
  input  logic          in_lt,
  input  logic          in_eq,
  input  logic [3:0]    in_and,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s1,
  output logic          out_s0,
  output logic [3:0]    out_sum,
  output logic          out_carry,
  output logic          out_gt,
  output logic          out_lt,
  output logic          out_eq,
  output logic [3:0]    out_and,
  output logic [AW:0]   count,
  output logic          dropped,
  output logic          flag_err
);

  typedef struct packed {
    logic       s1;
    logic       s0;
    logic [3:0] sum;
    logic       carry;
    logic       gt;
    logic       lt;
    logic       eq;
    logic [3:0] and_res;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  // A full FIFO refuses the write even when the head is popped this cycle.
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  assign wr_entry = '{s1: in_s1, s0: in_s0, sum: in_sum, carry: in_carry,
                      gt: in_gt, lt: in_lt, eq: in_eq, and_res: in_and};

  // NOTE: the storage array has no reset; count and rd_ptr decide what is visible,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (in_valid && full) dropped <= 1'b1;
    end
  end

`ifdef ALU_RESFIFO_FLAGCHK_EN
  logic flags_onehot;
  assign flags_onehot = ({in_gt, in_lt, in_eq} inside {3'b100, 3'b010, 3'b001});

  always_ff @(posedge clk) begin
    if (rst)                         flag_err <= 1'b0;
    else if (push && !flags_onehot)  flag_err <= 1'b1;
  end
`else
  assign flag_err = 1'b0;
`endif

  // NOTE: default assignment first so the empty path cannot infer a latch.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign out_s1    = head.s1;
  assign out_s0    = head.s0;
  assign out_sum   = head.sum;
  assign out_carry = head.carry;
  assign out_gt    = head.gt;
  assign out_lt    = head.lt;
  assign out_eq    = head.eq;
  assign out_and   = head.and_res;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo (DEPTH=4); flag_err expectation follows ALU_RESFIFO_FLAGCHK_EN.
module tb_alu_result_fifo;

  typedef struct packed {
    logic       s1;
    logic       s0;
    logic [3:0] sum;
    logic       carry;
    logic       gt;
    logic       lt;
    logic       eq;
    logic [3:0] andv;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  ent_t       drv;
  ent_t       obs;
  logic       out_s1, out_s0, out_carry, out_gt, out_lt, out_eq;
  logic [3:0] out_sum, out_and;
  logic [2:0] count;
  logic       dropped;
  logic       flag_err;

  int   vectors    = 0;
  int   miscompares = 0;
  ent_t q[$];
  ent_t exp_e;
  logic exp_ferr;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s1(drv.s1), .in_s0(drv.s0), .in_sum(drv.sum), .in_carry(drv.carry),
    .in_gt(drv.gt), .in_lt(drv.lt), .in_eq(drv.eq), .in_and(drv.andv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s1(out_s1), .out_s0(out_s0), .out_sum(out_sum), .out_carry(out_carry),
    .out_gt(out_gt), .out_lt(out_lt), .out_eq(out_eq), .out_and(out_and),
    .count(count), .dropped(dropped), .flag_err(flag_err)
  );

  assign obs = {out_s1, out_s0, out_sum, out_carry, out_gt, out_lt, out_eq, out_and};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [3:0] sum);
    ent_t e;
    e = '{s1: sum[0], s0: sum[1], sum: sum, carry: sum[2], gt: 1'b0, lt: 1'b0,
          eq: 1'b1, andv: ~sum};
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; drv = '0;
    cyc(); cyc();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || obs !== '0 ||
        dropped !== 1'b0 || flag_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b cnt=%0d obs=%h drop=%b ferr=%b, want 1 0 0 0 0 0",
               in_ready, out_valid, count, obs, dropped, flag_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    drv = '{s1: 1'b1, s0: 1'b1, sum: 4'b0110, carry: 1'b1, gt: 1'b1, lt: 1'b0,
            eq: 1'b0, andv: 4'b1001};
    in_valid = 1'b1; out_ready = 1'b0;
    q.push_back(drv);
    cyc();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || count !== 3'd1 || obs !== q[0]) begin
      miscompares++;
      $display("FAIL single_push: vld=%b cnt=%0d obs=%h, want 1 1 %h", out_valid, count, obs, q[0]);
    end
    out_ready = 1'b1;
    exp_e = q.pop_front();
    cyc();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0 || obs !== '0) begin
      miscompares++;
      $display("FAIL single_pop: vld=%b cnt=%0d obs=%h, want 0 0 0 (popped %h)",
               out_valid, count, obs, exp_e);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 4; i++) begin
      drv = mk(4'(i)); in_valid = 1'b1; out_ready = 1'b0;
      q.push_back(drv);
      cyc();
    end
    vectors++;
    if (count !== 3'd4 || in_ready !== 1'b0 || dropped !== 1'b0) begin
      miscompares++;
      $display("FAIL fill: cnt=%0d rdy=%b drop=%b, want 4 0 0", count, in_ready, dropped);
    end
    drv = mk(4'd5);
    cyc();
    vectors++;
    if (dropped !== 1'b1 || count !== 3'd4) begin
      miscompares++;
      $display("FAIL overflow: drop=%b cnt=%0d, want 1 4", dropped, count);
    end
    // Full with pop and offer together: pop only, no pass-through.
    drv = mk(4'd6); out_ready = 1'b1;
    vectors++;
    exp_e = q.pop_front();
    if (obs !== exp_e) begin
      miscompares++;
      $display("FAIL full_pop_head: obs=%h want %h", obs, exp_e);
    end
    cyc();
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd3) begin
      miscompares++;
      $display("FAIL no_passthrough: cnt=%0d want 3", count);
    end
    while (q.size() > 0) begin
      exp_e = q.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || obs !== exp_e) begin
        miscompares++;
        $display("FAIL drain: vld=%b obs=%h want 1 %h", out_valid, obs, exp_e);
      end
      cyc();
    end
    out_ready = 1'b0;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || obs !== '0 || flag_err !== 1'b0) begin
      miscompares++;
      $display("FAIL drained_empty: cnt=%0d vld=%b obs=%h ferr=%b, want 0 0 0 0",
               count, out_valid, obs, flag_err);
    end
    // Popping an empty FIFO must not underflow.
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    vectors++;
    if (count !== 3'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_pop: cnt=%0d rdy=%b, want 0 1", count, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drv = mk(4'(8 + i)); in_valid = 1'b1;
      q.push_back(drv);
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      drv = mk(4'(10 + i)); in_valid = 1'b1; out_ready = 1'b1;
      exp_e = q.pop_front();
      q.push_back(drv);
      vectors++;
      if (obs !== exp_e) begin
        miscompares++;
        $display("FAIL b2b_head[%0d]: obs=%h want %h", i, obs, exp_e);
      end
      cyc();
      vectors++;
      if (count !== 3'd2) begin
        miscompares++;
        $display("FAIL b2b_count[%0d]: cnt=%0d want 2", i, count);
      end
    end
    in_valid = 1'b0;
    while (q.size() > 0) begin
      exp_e = q.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || obs !== exp_e) begin
        miscompares++;
        $display("FAIL b2b_drain: vld=%b obs=%h want 1 %h", out_valid, obs, exp_e);
      end
      cyc();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drv = mk(4'(3 + i)); in_valid = 1'b1;
      q.push_back(drv);
      cyc();
    end
    vectors++;
    if (count !== 3'd3) begin
      miscompares++;
      $display("FAIL mid_pre: cnt=%0d want 3", count);
    end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || dropped !== 1'b0 || in_ready !== 1'b1 ||
        obs !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: cnt=%0d vld=%b drop=%b rdy=%b obs=%h, want 0 0 0 1 0",
               count, out_valid, dropped, in_ready, obs);
    end
  endtask

  task automatic test_flagchk();
`ifdef ALU_RESFIFO_FLAGCHK_EN
    exp_ferr = 1'b1;
`else
    exp_ferr = 1'b0;
`endif
    drv = '{s1: 1'b0, s0: 1'b1, sum: 4'b1010, carry: 1'b0, gt: 1'b1, lt: 1'b1,
            eq: 1'b0, andv: 4'b0101};
    in_valid = 1'b1;
    q.push_back(drv);
    cyc();
    in_valid = 1'b0;
    exp_e = q.pop_front();
    vectors++;
    if (flag_err !== exp_ferr || obs !== exp_e || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flagchk: ferr=%b obs=%h vld=%b, want %b %h 1", flag_err, obs, out_valid,
               exp_ferr, exp_e);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    cyc();
    vectors++;
    if (flag_err !== exp_ferr || count !== 3'd0) begin
      miscompares++;
      $display("FAIL flag_sticky: ferr=%b cnt=%0d, want %b 0", flag_err, count, exp_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_reset_midstream();
    test_flagchk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
